// File: rtl/layer_mixer.sv
// Two-stage priority compositor with one-level ghost blending
// and a per-frame collision latch between two layer groups.
module layer_mixer #(
    parameter int NUM_LAYERS = 16,
    parameter int COLOR_W = 8,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK_A = 16'h0001,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK_B = 16'h0800
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic                            i_v_sync,
    input  logic [NUM_LAYERS-1:0]           i_layer_hit,
    input  logic [NUM_LAYERS-1:0]           i_layer_en,
    input  logic [NUM_LAYERS-1:0]           i_layer_ghost,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] i_layer_rgb,
    input  logic [3*COLOR_W-1:0]            i_bg_rgb,
    output logic                            o_valid,
    output logic [COLOR_W-1:0]              o_red,
    output logic [COLOR_W-1:0]              o_green,
    output logic [COLOR_W-1:0]              o_blue,
    output logic [$clog2(NUM_LAYERS)-1:0]   o_top_layer,
    output logic                            o_top_is_layer,
    output logic                            o_frame_strobe,
    output logic                            o_collision
);

    localparam int IDX_W = $clog2(NUM_LAYERS);
    localparam int RGB_W = 3 * COLOR_W;

    logic [NUM_LAYERS-1:0] eh;
    logic                  top_found;
    logic                  below_found;
    logic [IDX_W-1:0]      top_idx;
    logic [RGB_W-1:0]      top_rgb;
    logic [RGB_W-1:0]      below_rgb;
    logic                  coll_now;

    // Single scan picks the first and second effective hits.
    always_comb begin
        eh = i_layer_hit & i_layer_en;
        top_found = 1'b0;
        below_found = 1'b0;
        top_idx = '0;
        top_rgb = i_bg_rgb;
        below_rgb = i_bg_rgb;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (eh[k]) begin
                if (!top_found) begin
                    top_found = 1'b1;
                    top_idx = IDX_W'(k);
                    top_rgb = i_layer_rgb[k*RGB_W +: RGB_W];
                end else if (!below_found) begin
                    below_found = 1'b1;
                    below_rgb = i_layer_rgb[k*RGB_W +: RGB_W];
                end
            end
        end
    end

    assign coll_now = i_valid
                    & (|(eh & COLL_MASK_A))
                    & (|(eh & COLL_MASK_B));

    logic [NUM_LAYERS-1:0] s1_eh;
    logic [NUM_LAYERS-1:0] s1_ghost;
    logic [RGB_W-1:0]      s1_top_rgb;
    logic [RGB_W-1:0]      s1_below_rgb;
    logic [IDX_W-1:0]      s1_top;
    logic                  s1_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_eh <= '0;
            s1_ghost <= '0;
            s1_top_rgb <= '0;
            s1_below_rgb <= '0;
            s1_top <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_eh <= eh;
            s1_ghost <= i_layer_ghost;
            s1_top_rgb <= top_rgb;
            s1_below_rgb <= below_rgb;
            s1_top <= top_idx;
            s1_valid <= i_valid;
        end
    end

    logic                 s1_is_layer;
    logic                 top_ghost;
    logic [COLOR_W:0]     ch_sum [3];
    logic [RGB_W-1:0]     blend_rgb;
    logic [RGB_W-1:0]     mix_rgb;

    assign s1_is_layer = |s1_eh;
    assign top_ghost = s1_is_layer & s1_ghost[s1_top];

    // Sum carries one extra bit so the halving never overflows.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            ch_sum[c] = {1'b0, s1_top_rgb[c*COLOR_W +: COLOR_W]}
                      + {1'b0, s1_below_rgb[c*COLOR_W +: COLOR_W]};
            blend_rgb[c*COLOR_W +: COLOR_W] = ch_sum[c][COLOR_W:1];
        end
    end

    assign mix_rgb = top_ghost ? blend_rgb : s1_top_rgb;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_red <= '0;
            o_green <= '0;
            o_blue <= '0;
            o_top_layer <= '0;
            o_top_is_layer <= 1'b0;
        end else begin
            o_valid <= s1_valid;
            o_red <= mix_rgb[RGB_W-1 -: COLOR_W];
            o_green <= mix_rgb[2*COLOR_W-1 -: COLOR_W];
            o_blue <= mix_rgb[COLOR_W-1:0];
            o_top_layer <= s1_is_layer ? s1_top : '0;
            o_top_is_layer <= s1_is_layer;
        end
    end

    logic vs_prev;
    logic vs_armed;
    logic coll_acc;
    logic frame_edge;

    // Arming needs a low sample, so a level held high across reset is ignored.
    assign frame_edge = i_v_sync & ~vs_prev & vs_armed;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vs_prev <= 1'b0;
            vs_armed <= 1'b0;
            coll_acc <= 1'b0;
            o_frame_strobe <= 1'b0;
            o_collision <= 1'b0;
        end else begin
            vs_prev <= i_v_sync;
            vs_armed <= vs_armed | ~i_v_sync;
            o_frame_strobe <= frame_edge;
            if (frame_edge) begin
                o_collision <= coll_acc | coll_now;
                coll_acc <= 1'b0;
            end else if (coll_now) begin
                coll_acc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer.
module tb_layer_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        vs;
    logic [15:0] hit;
    logic [15:0] en;
    logic [15:0] ghost;
    logic [383:0] rgb;
    logic [23:0] bg;
    logic        o_valid;
    logic [7:0]  o_red;
    logic [7:0]  o_green;
    logic [7:0]  o_blue;
    logic [3:0]  o_top_layer;
    logic        o_top_is_layer;
    logic        o_frame_strobe;
    logic        o_collision;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    layer_mixer dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .i_v_sync(vs),
        .i_layer_hit(hit),
        .i_layer_en(en),
        .i_layer_ghost(ghost),
        .i_layer_rgb(rgb),
        .i_bg_rgb(bg),
        .o_valid(o_valid),
        .o_red(o_red),
        .o_green(o_green),
        .o_blue(o_blue),
        .o_top_layer(o_top_layer),
        .o_top_is_layer(o_top_is_layer),
        .o_frame_strobe(o_frame_strobe),
        .o_collision(o_collision)
    );

    task automatic set_rgb(input int k, input logic [23:0] v);
        rgb[k*24 +: 24] = v;
    endtask

    task automatic clear_px();
        hit = '0;
        ghost = '0;
        en = '1;
    endtask

    task automatic push_pixel();
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        vs = 1'b0;
        clear_px();
        rgb = '0;
        bg = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got %b want 0", o_valid);
        end
        total++;
        if ({o_red, o_green, o_blue} !== 24'h0) begin
            bad++;
            $display("FAIL reset_rgb got %h want 000000", {o_red, o_green, o_blue});
        end
        total++;
        if ({o_frame_strobe, o_collision, o_top_is_layer} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got %b want 000",
                     {o_frame_strobe, o_collision, o_top_is_layer});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        clear_px();
        hit[3] = 1'b1;
        hit[5] = 1'b1;
        set_rgb(3, 24'h112233);
        set_rgb(5, 24'hAABBCC);
        push_pixel();
        total++;
        if ({o_red, o_green, o_blue} !== 24'h112233) begin
            bad++;
            $display("FAIL prio_rgb got %h want 112233", {o_red, o_green, o_blue});
        end
        total++;
        if ({o_valid, o_top_is_layer, o_top_layer} !== {2'b11, 4'd3}) begin
            bad++;
            $display("FAIL prio_top got v=%b l=%b t=%0d want v=1 l=1 t=3",
                     o_valid, o_top_is_layer, o_top_layer);
        end
        @(posedge clk);
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL prio_valid_drop got %b want 0", o_valid);
        end
    endtask

    task automatic test_enable();
        clear_px();
        hit[0] = 1'b1;
        hit[2] = 1'b1;
        en[0] = 1'b0;
        set_rgb(0, 24'hDEADBE);
        set_rgb(2, 24'h334455);
        push_pixel();
        total++;
        if ({o_top_layer, o_red, o_green, o_blue} !== {4'd2, 24'h334455}) begin
            bad++;
            $display("FAIL enable_mask got t=%0d rgb=%h want t=2 rgb=334455",
                     o_top_layer, {o_red, o_green, o_blue});
        end
        clear_px();
        bg = 24'h445566;
        push_pixel();
        total++;
        if ({o_red, o_green, o_blue} !== 24'h445566) begin
            bad++;
            $display("FAIL bg_rgb got %h want 445566", {o_red, o_green, o_blue});
        end
        total++;
        if ({o_top_is_layer, o_top_layer} !== 5'b0) begin
            bad++;
            $display("FAIL bg_top got l=%b t=%0d want l=0 t=0",
                     o_top_is_layer, o_top_layer);
        end
    endtask

    task automatic test_ghost();
        clear_px();
        hit[1] = 1'b1;
        hit[4] = 1'b1;
        ghost[1] = 1'b1;
        ghost[4] = 1'b1;
        set_rgb(1, 24'hFF0000);
        set_rgb(4, 24'h01FF80);
        push_pixel();
        total++;
        if ({o_red, o_green, o_blue} !== 24'h807F40) begin
            bad++;
            $display("FAIL ghost_blend got %h want 807F40", {o_red, o_green, o_blue});
        end
        total++;
        if (o_top_layer !== 4'd1) begin
            bad++;
            $display("FAIL ghost_top got %0d want 1", o_top_layer);
        end
        hit[4] = 1'b0;
        bg = 24'h000000;
        push_pixel();
        total++;
        if ({o_red, o_green, o_blue} !== 24'h7F0000) begin
            bad++;
            $display("FAIL ghost_bg got %h want 7F0000", {o_red, o_green, o_blue});
        end
    endtask

    task automatic test_back_to_back();
        clear_px();
        bg = 24'h102030;
        set_rgb(6, 24'h0A0B0C);
        set_rgb(7, 24'h204060);
        @(negedge clk);
        hit[6] = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        hit = '0;
        @(posedge clk);
        #1;
        total++;
        if ({o_valid, o_top_layer, o_red, o_green, o_blue} !== {1'b1, 4'd6, 24'h0A0B0C}) begin
            bad++;
            $display("FAIL b2b_first got v=%b t=%0d rgb=%h want v=1 t=6 rgb=0A0B0C",
                     o_valid, o_top_layer, {o_red, o_green, o_blue});
        end
        @(negedge clk);
        hit[7] = 1'b1;
        ghost[7] = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_top_is_layer, o_red, o_green, o_blue} !== {1'b0, 24'h102030}) begin
            bad++;
            $display("FAIL b2b_second got l=%b rgb=%h want l=0 rgb=102030",
                     o_top_is_layer, {o_red, o_green, o_blue});
        end
        @(negedge clk);
        valid = 1'b0;
        clear_px();
        @(posedge clk);
        #1;
        total++;
        if ({o_valid, o_top_layer, o_red, o_green, o_blue} !== {1'b1, 4'd7, 24'h183048}) begin
            bad++;
            $display("FAIL b2b_third got v=%b t=%0d rgb=%h want v=1 t=7 rgb=183048",
                     o_valid, o_top_layer, {o_red, o_green, o_blue});
        end
    endtask

    task automatic test_collision();
        clear_px();
        hit[0] = 1'b1;
        hit[11] = 1'b1;
        push_pixel();
        clear_px();
        repeat (2) @(negedge clk);
        total++;
        if (o_frame_strobe !== 1'b0) begin
            bad++;
            $display("FAIL coll_no_early_strobe got %b want 0", o_frame_strobe);
        end
        vs = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b11) begin
            bad++;
            $display("FAIL coll_close got s=%b c=%b want s=1 c=1",
                     o_frame_strobe, o_collision);
        end
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b01) begin
            bad++;
            $display("FAIL coll_hold got s=%b c=%b want s=0 c=1",
                     o_frame_strobe, o_collision);
        end
        @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b10) begin
            bad++;
            $display("FAIL coll_clear got s=%b c=%b want s=1 c=0",
                     o_frame_strobe, o_collision);
        end
    endtask

    task automatic test_edge_collision();
        @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        valid = 1'b1;
        hit[0] = 1'b1;
        hit[11] = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b11) begin
            bad++;
            $display("FAIL edge_coll got s=%b c=%b want s=1 c=1",
                     o_frame_strobe, o_collision);
        end
        @(negedge clk);
        valid = 1'b0;
        vs = 1'b0;
        repeat (3) @(negedge clk);
        clear_px();
        vs = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b10) begin
            bad++;
            $display("FAIL edge_next_frame got s=%b c=%b want s=1 c=0",
                     o_frame_strobe, o_collision);
        end
    endtask

    task automatic test_reset_mid();
        clear_px();
        set_rgb(0, 24'h5A5A5A);
        @(negedge clk);
        vs = 1'b0;
        hit[0] = 1'b1;
        hit[11] = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (o_collision !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_coll got %b want 1", o_collision);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_valid, o_red} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("FAIL rst_pre_pipe got v=%b r=%h want v=1 r=5A", o_valid, o_red);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({o_valid, o_red, o_green, o_blue, o_top_layer, o_top_is_layer,
             o_frame_strobe, o_collision} !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got v=%b rgb=%h t=%0d l=%b s=%b c=%b want all 0",
                     o_valid, {o_red, o_green, o_blue}, o_top_layer,
                     o_top_is_layer, o_frame_strobe, o_collision);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        clear_px();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (o_frame_strobe !== 1'b0) begin
                bad++;
                $display("FAIL rst_vs_high_strobe cycle %0d got %b want 0",
                         i, o_frame_strobe);
            end
        end
        @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({o_frame_strobe, o_collision} !== 2'b10) begin
            bad++;
            $display("FAIL rst_first_frame got s=%b c=%b want s=1 c=0",
                     o_frame_strobe, o_collision);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_enable();
        test_ghost();
        test_back_to_back();
        test_collision();
        test_edge_collision();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
